// File: rtl/lut_sweep_checker_pkg.sv
// Shared definitions for the LUT fabric sweep checker: FSM encoding, MISR
// constants and the default fabric widths shared with the generated fabric.
package lut_sweep_checker_pkg;

   localparam int DEF_NUM_IN  = 4;
   localparam int DEF_NUM_OUT = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   // One MISR step: shift, fold the feedback polynomial, then mix in the data word.
   function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] data);
      return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
   endfunction

endpackage

// File: rtl/lut_sweep_checker_misr16.sv
// 16-bit multiple-input signature register; reusable by other fabric checkers.
module misr16
   import lut_sweep_checker_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [15:0] data,
   output logic [15:0] sig
);

   logic [15:0] sig_r;

   // Signature register: seed on reset or init, compact one word per enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_r <= MISR_SEED;
      end else if (init) begin
         sig_r <= MISR_SEED;
      end else if (en) begin
         sig_r <= misr_next(sig_r, data);
      end else begin
         sig_r <= sig_r;
      end
   end

   assign sig = sig_r;

endmodule

// File: rtl/lut_sweep_checker.sv
// Exhaustive sweep harness: walks every fabric input vector, compares the
// settled response against a loaded truth table and compacts it into a MISR.
module lut_sweep_checker
   import lut_sweep_checker_pkg::*;
#(
   parameter int NUM_IN  = DEF_NUM_IN,
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int SETTLE  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [NUM_IN-1:0]  stim_out,
   input  logic [NUM_OUT-1:0] resp_in,
   input  logic               exp_we,
   input  logic [NUM_IN-1:0]  exp_addr,
   input  logic [NUM_OUT-1:0] exp_wdata,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [NUM_IN:0]    err_count,
   output logic [NUM_IN-1:0]  first_err_vec,
   output logic [NUM_OUT-1:0] first_err_resp,
   output logic [15:0]        signature
);

   localparam int ROWS  = 1 << NUM_IN;
   localparam int ERR_W = NUM_IN + 1;
   localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [NUM_IN-1:0] VEC_LAST    = NUM_IN'(ROWS - 1);

   logic [1:0]         state_r;
   logic [NUM_IN-1:0]  vec_r;
   logic [SW-1:0]      settle_r;
   logic [ERR_W-1:0]   err_count_r;
   logic [NUM_IN-1:0]  first_err_vec_r;
   logic [NUM_OUT-1:0] first_err_resp_r;
   logic               busy_r;
   logic               done_r;
   logic               pass_r;
   logic [NUM_OUT-1:0] exp_mem_r [ROWS];

   logic               idle_like_s;
   logic               start_s;
   logic               sample_s;
   logic               mismatch_s;
   logic [ERR_W-1:0]   err_next_s;

   // Decode sweep control and the per-vector comparison result.
   always_comb begin
      idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
      start_s     = idle_like_s && start;
      sample_s    = (state_r == ST_SAMPLE);
      mismatch_s  = sample_s && (exp_mem_r[vec_r] != resp_in);
      err_next_s  = err_count_r + ERR_W'(mismatch_s);
   end

   // Expected truth table; writable only while no sweep is running.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROWS; i++) begin
            exp_mem_r[i] <= '0;
         end
      end else if (idle_like_s && exp_we) begin
         exp_mem_r[exp_addr] <= exp_wdata;
      end else begin
         exp_mem_r <= exp_mem_r;
      end
   end

   // Sweep FSM with its vector, settle counter and error bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         vec_r            <= '0;
         settle_r         <= '0;
         err_count_r      <= '0;
         first_err_vec_r  <= '0;
         first_err_resp_r <= '0;
         busy_r           <= 1'b0;
         done_r           <= 1'b0;
         pass_r           <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r          <= ST_DRIVE;
                  vec_r            <= '0;
                  settle_r         <= '0;
                  err_count_r      <= '0;
                  first_err_vec_r  <= '0;
                  first_err_resp_r <= '0;
                  busy_r           <= 1'b1;
                  done_r           <= 1'b0;
                  pass_r           <= 1'b0;
               end
            end
            ST_DRIVE: begin
               if (settle_r == SETTLE_LAST) begin
                  settle_r <= '0;
                  state_r  <= ST_SAMPLE;
               end else begin
                  settle_r <= settle_r + SW'(1);
               end
            end
            ST_SAMPLE: begin
               err_count_r <= err_next_s;
               // A zero running count means this is the first mismatch of the sweep.
               if (mismatch_s && (err_count_r == '0)) begin
                  first_err_vec_r  <= vec_r;
                  first_err_resp_r <= resp_in;
               end
               if (vec_r == VEC_LAST) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (err_next_s == '0);
               end else begin
                  vec_r   <= vec_r + NUM_IN'(1);
                  state_r <= ST_DRIVE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   misr16 u_misr (
      .clk  (clk),
      .rst  (rst),
      .init (start_s),
      .en   (sample_s),
      .data (16'(resp_in)),
      .sig  (signature)
   );

   assign stim_out       = vec_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign err_count      = err_count_r;
   assign first_err_vec  = first_err_vec_r;
   assign first_err_resp = first_err_resp_r;

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Self-checking bench: a behavioural LUT fabric model closes the loop and a
// scoreboard of expected sweep results is compared when each sweep finishes.
module tb_lut_sweep_checker;

   localparam int NI   = 4;
   localparam int NO   = 16;
   localparam int ROWS = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NI-1:0] stim_out;
   logic [NO-1:0] resp_in;
   logic          exp_we;
   logic [NI-1:0] exp_addr;
   logic [NO-1:0] exp_wdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic [NI:0]   err_count;
   logic [NI-1:0] first_err_vec;
   logic [NO-1:0] first_err_resp;
   logic [15:0]   signature;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]  err;
      logic [3:0]  fv;
      logic [15:0] fr;
      logic        pass;
      logic [15:0] sig;
   } res_t;

   res_t        sb_q[$];
   logic [3:0]  stim_q[$];
   logic [NO-1:0] tbl [ROWS];

   always #5 clk = ~clk;

   lut_sweep_checker dut (
      .clk(clk), .rst(rst), .start(start), .stim_out(stim_out), .resp_in(resp_in),
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata), .busy(busy),
      .done(done), .pass(pass), .err_count(err_count), .first_err_vec(first_err_vec),
      .first_err_resp(first_err_resp), .signature(signature)
   );

   // Configured fabric: an arbitrary mix of functions of the 4 inputs.
   function automatic logic [15:0] fab_f(input logic [3:0] v);
      return {v, ~v, v ^ 4'h5, {v[0] & v[1], v[2] | v[3], v[1] ^ v[2], ~v[3]}};
   endfunction

   always_comb resp_in = fab_f(stim_out);

   function automatic res_t model();
      res_t r;
      logic [15:0] s;
      logic [15:0] d;
      r = '0;
      s = 16'hFFFF;
      for (int v = 0; v < ROWS; v++) begin
         d = fab_f(4'(v));
         if (tbl[v] !== d) begin
            if (r.err == 5'd0) begin
               r.fv = 4'(v);
               r.fr = d;
            end
            r.err = r.err + 5'd1;
         end
         s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
      end
      r.sig  = s;
      r.pass = (r.err == 5'd0);
      return r;
   endfunction

   task automatic set_table_good();
      for (int v = 0; v < ROWS; v++) tbl[v] = fab_f(4'(v));
   endtask

   task automatic load_table();
      for (int v = 0; v < ROWS; v++) begin
         @(negedge clk);
         exp_we    = 1'b1;
         exp_addr  = 4'(v);
         exp_wdata = tbl[v];
      end
      @(negedge clk);
      exp_we = 1'b0;
   endtask

   task automatic run_sweep(input bit mon, input string tag);
      res_t e;
      bit   got;
      int   dn;
      got = 1'b0;
      dn  = 0;
      sb_q.push_back(model());
      if (mon) for (int i = 0; i < 48; i++) stim_q.push_back(4'(i / 3));
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= 200 && !got; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || err_count !== 5'd0 || first_err_vec !== 4'd0) begin
               errors++;
               $display("FAIL %s start_clear: busy=%b done=%b err=%0d fvec=%0d, need 1 0 0 0", tag, busy, done, err_count, first_err_vec);
            end
         end
         if (done === 1'b1) begin
            got = 1'b1;
            dn  = n;
         end else if (mon) begin
            if (stim_q.size() > 0) begin
               logic [3:0] es;
               es = stim_q.pop_front();
               checks++;
               if (stim_out !== es || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL %s stim n=%0d: stim=%0d busy=%b, need stim=%0d busy=1", tag, n, stim_out, busy, es);
               end
            end
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
            if (n == 20) begin
               exp_we = 1'b1; exp_addr = 4'd0; exp_wdata = ~tbl[0];
            end
            if (n == 21) exp_we = 1'b0;
         end
      end
      start  = 1'b0;
      exp_we = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: done never rose within 200 cycles, need 49", tag);
      end else if (dn != 49) begin
         errors++;
         $display("FAIL %s latency: done after %0d cycles, need 49", tag, dn);
      end
      if (mon) begin
         checks++;
         if (stim_q.size() != 0) begin
            errors++;
            $display("FAIL %s stim_count: %0d vectors unseen, need 0", tag, stim_q.size());
            stim_q.delete();
         end
      end
      checks++;
      if (err_count !== e.err) begin
         errors++; $display("FAIL %s err_count: got %0d need %0d", tag, err_count, e.err);
      end
      checks++;
      if (pass !== e.pass || busy !== 1'b0) begin
         errors++; $display("FAIL %s pass/busy: got %b/%b need %b/0", tag, pass, busy, e.pass);
      end
      checks++;
      if (first_err_vec !== e.fv || first_err_resp !== e.fr) begin
         errors++;
         $display("FAIL %s first_err: got vec=%0d resp=%h need vec=%0d resp=%h", tag, first_err_vec, first_err_resp, e.fv, e.fr);
      end
      checks++;
      if (signature !== e.sig) begin
         errors++; $display("FAIL %s signature: got %h need %h", tag, signature, e.sig);
      end
      checks++;
      if (stim_out !== 4'd15) begin
         errors++; $display("FAIL %s stim_hold: got %0d need 15", tag, stim_out);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 5'd0 || stim_out !== 4'd0 ||
          first_err_vec !== 4'd0 || first_err_resp !== 16'd0 || signature !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b pass=%b err=%0d stim=%0d fv=%0d fr=%h sig=%h, need zeros and sig=ffff",
                  busy, done, pass, err_count, stim_out, first_err_vec, first_err_resp, signature);
      end
   endtask

   task automatic test_pass();
      set_table_good();
      load_table();
      run_sweep(1'b0, "pass");
   endtask

   task automatic test_single_err();
      set_table_good();
      tbl[5] = tbl[5] ^ 16'h0008;
      load_table();
      run_sweep(1'b0, "single_err");
   endtask

   task automatic test_two_err();
      set_table_good();
      tbl[2] = tbl[2] ^ 16'h8001;
      tbl[9] = ~tbl[9];
      load_table();
      run_sweep(1'b0, "two_err");
   endtask

   task automatic test_monitor();
      set_table_good();
      load_table();
      run_sweep(1'b1, "monitor");
      run_sweep(1'b0, "rerun");
   endtask

   task automatic test_rst_mid();
      bit hit;
      hit = 1'b0;
      set_table_good();
      load_table();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         if (stim_out === 4'd7) hit = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!hit) begin
         errors++; $display("FAIL rst_mid reach7: stim=%0d, need 7 within 100 cycles", stim_out);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || stim_out !== 4'd0 || signature !== 16'hFFFF || err_count !== 5'd0) begin
         errors++;
         $display("FAIL rst_mid state: busy=%b done=%b stim=%0d sig=%h err=%0d, need 0 0 0 ffff 0",
                  busy, done, stim_out, signature, err_count);
      end
      rst = 1'b0;
      // The table was cleared by reset, so a sweep without reloading sees all-zero rows.
      for (int v = 0; v < ROWS; v++) tbl[v] = '0;
      run_sweep(1'b0, "cleared_table");
      set_table_good();
      load_table();
      run_sweep(1'b0, "after_rst");
   endtask

   task automatic test_back_to_back();
      set_table_good();
      tbl[5] = tbl[5] ^ 16'h0008;
      load_table();
      run_sweep(1'b0, "b2b_fail");
      set_table_good();
      load_table();
      run_sweep(1'b0, "b2b_pass");
   endtask

   initial begin
      test_reset();
      test_pass();
      test_single_err();
      test_two_err();
      test_monitor();
      test_rst_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
